// File: rtl/softmax_sched.sv
// -----------------------------------------------------------------------------
// softmax_sched
//   Collects SYS and BR weight/bias row requests into two small FIFOs and
//   dispatches them one at a time to a softmax engine. The engine is given
//   one descriptor, and the scheduler then waits for its done pulse or
//   declares it hung after TIMEOUT wait cycles. When both queues hold work,
//   arbitration is round-robin between the two request types.
//
// Parameters
//   DEPTH    per-type queue depth (2, 4 or 8)
//   TIMEOUT  WAIT cycles allowed before oTimeout fires
//
// Ports
//   clk, resetn                      clock, async active-low reset
//   iEn                              dispatch enable (queues always accept)
//   iFlush                           synchronous clear of queues and FSM
//   iSys_req_valid/idx, oSys_req_ready   SYS request handshake (8-bit idx)
//   iBr_req_valid/idx,  oBr_req_ready    BR request handshake (12-bit idx)
//   oFIFO_valid, oFIFO_data          registered one-cycle dispatch strobe and
//                                    descriptor {type, payload}; type 1 = SYS
//   iEngine_done                     engine finished (used only in WAIT)
//   oBusy                            FSM is not in IDLE
//   oTimeout                         one-cycle hung-engine pulse
//   oDrop_cnt                        saturating count of refused requests
// -----------------------------------------------------------------------------
module softmax_sched #(
    parameter int         DEPTH   = 4,
    parameter logic [6:0] TIMEOUT = 7'd100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iEn,
    input  logic        iFlush,
    input  logic        iSys_req_valid,
    input  logic [7:0]  iSys_req_idx,
    output logic        oSys_req_ready,
    input  logic        iBr_req_valid,
    input  logic [11:0] iBr_req_idx,
    output logic        oBr_req_ready,
    output logic        oFIFO_valid,
    output logic [12:0] oFIFO_data,
    input  logic        iEngine_done,
    output logic        oBusy,
    output logic        oTimeout,
    output logic [7:0]  oDrop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Queue storage and bookkeeping
    // ---------------------------------------------------------------------
    logic [7:0]    sys_mem [DEPTH];
    logic [AW-1:0] sys_wr, sys_rd;
    logic [CW-1:0] sys_cnt;
    logic [11:0]   br_mem [DEPTH];
    logic [AW-1:0] br_wr, br_rd;
    logic [CW-1:0] br_cnt;

    logic        sys_push, sys_pop, sys_avail, sys_drop;
    logic        br_push, br_pop, br_avail, br_drop;
    logic [7:0]  sys_head;
    logic [11:0] br_head;
    logic [8:0]  drop_sum;

    // FSM and output register next-state values
    state_t      state, state_next;
    logic        valid_next, timeout_next, last_br, last_br_next, grant_sys;
    logic [12:0] data_next;
    logic [6:0]  wcnt, wcnt_next;

    assign oSys_req_ready = (sys_cnt != CW'(DEPTH));
    assign oBr_req_ready  = (br_cnt  != CW'(DEPTH));

    // A flush swallows any request presented in the same cycle: it is
    // neither stored nor counted as a drop.
    assign sys_push = iSys_req_valid & oSys_req_ready & ~iFlush;
    assign br_push  = iBr_req_valid  & oBr_req_ready  & ~iFlush;
    assign sys_drop = iSys_req_valid & ~oSys_req_ready & ~iFlush;
    assign br_drop  = iBr_req_valid  & ~oBr_req_ready  & ~iFlush;

    // An empty queue can still supply a head this cycle from the incoming
    // request, so an idle scheduler dispatches on the acceptance edge itself.
    // The entry is then pushed and popped together and occupancy stays 0.
    assign sys_avail = (sys_cnt != '0) | sys_push;
    assign br_avail  = (br_cnt  != '0) | br_push;
    assign sys_head  = (sys_cnt != '0) ? sys_mem[sys_rd] : iSys_req_idx;
    assign br_head   = (br_cnt  != '0) ? br_mem[br_rd]   : iBr_req_idx;

    assign drop_sum = {1'b0, oDrop_cnt} + {8'd0, sys_drop} + {8'd0, br_drop};

    // NOTE: queue payload arrays carry no reset; validity is tracked solely by
    // the pointers and occupancy counters, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (sys_push) sys_mem[sys_wr] <= iSys_req_idx;
        if (br_push)  br_mem[br_wr]   <= iBr_req_idx;
    end

    // NOTE: every state register uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sys_wr    <= '0;
            sys_rd    <= '0;
            sys_cnt   <= '0;
            br_wr     <= '0;
            br_rd     <= '0;
            br_cnt    <= '0;
            oDrop_cnt <= '0;
        end else if (iFlush) begin
            sys_wr  <= '0;
            sys_rd  <= '0;
            sys_cnt <= '0;
            br_wr   <= '0;
            br_rd   <= '0;
            br_cnt  <= '0;
        end else begin
            if (sys_push) sys_wr <= sys_wr + AW'(1);
            if (sys_pop)  sys_rd <= sys_rd + AW'(1);
            if (br_push)  br_wr  <= br_wr  + AW'(1);
            if (br_pop)   br_rd  <= br_rd  + AW'(1);

            case ({sys_push, sys_pop})
                2'b10:   sys_cnt <= sys_cnt + CW'(1);
                2'b01:   sys_cnt <= sys_cnt - CW'(1);
                default: ;
            endcase
            case ({br_push, br_pop})
                2'b10:   br_cnt <= br_cnt + CW'(1);
                2'b01:   br_cnt <= br_cnt - CW'(1);
                default: ;
            endcase

            oDrop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // ---------------------------------------------------------------------
    // Dispatch FSM: next-state and output decode
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        sys_pop      = 1'b0;
        br_pop       = 1'b0;
        grant_sys    = 1'b0;
        valid_next   = 1'b0;
        timeout_next = 1'b0;
        data_next    = oFIFO_data;
        wcnt_next    = wcnt;
        last_br_next = last_br;

        if (iFlush) begin
            state_next = IDLE;
            wcnt_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iEn && (sys_avail || br_avail)) begin
                        // SYS wins when alone, or on a tie when BR went last.
                        grant_sys = sys_avail && (!br_avail || last_br);
                        if (grant_sys) begin
                            sys_pop      = 1'b1;
                            data_next    = {1'b1, 4'b0000, sys_head};
                            last_br_next = 1'b0;
                        end else begin
                            br_pop       = 1'b1;
                            data_next    = {1'b0, br_head};
                            last_br_next = 1'b1;
                        end
                        valid_next = 1'b1;
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt_next  = '0;
                    state_next = WAIT;
                end
                WAIT: begin
                    // Done outranks a timeout landing in the same cycle.
                    if (iEngine_done) begin
                        state_next = IDLE;
                    end else if (wcnt == TIMEOUT - 7'd1) begin
                        timeout_next = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        wcnt_next = wcnt + 7'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            oFIFO_valid <= 1'b0;
            oFIFO_data  <= '0;
            oBusy       <= 1'b0;
            oTimeout    <= 1'b0;
            wcnt        <= '0;
            last_br     <= 1'b1;
        end else begin
            state       <= state_next;
            oFIFO_valid <= valid_next;
            oFIFO_data  <= data_next;
            oBusy       <= (state_next != IDLE);
            oTimeout    <= timeout_next;
            wcnt        <= wcnt_next;
            last_br     <= last_br_next;
        end
    end

endmodule
